seg_scan_nx7: RTL and testbench

Parametrised multiplexed 7-segment display driver. Scans NUM_DIGITS hex digits over a shared 8-bit segment bus. Adds features the fixed 4-digit scanner lacks: per-digit decimal point, per-digit blanking, leading-zero suppression, 16-level PWM brightness and one-phase anti-ghost dead time. Display data is snapshotted once per frame, so the display never shows a torn value.

---
 rtl/seg_pkg.sv | 21 ++
 rtl/seg_lz_mask.sv | 22 ++
 rtl/seg_scan_nx7.sv | 110 +++++++++++
 tb/tb_seg_scan_nx7.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment scanners.
// Segment codes are active-low with bit order b,A,f,C,g,D,dp,e (bit7..bit0).
package seg_pkg;

  localparam int unsigned SEG_DP_BIT  = 1;
  localparam logic [7:0]  SEG_ALL_OFF = 8'hFF;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'h0A, 8'h6F, 8'h32, 8'h23, 8'h47, 8'h83, 8'h82, 8'h2F,
    8'h02, 8'h03, 8'h06, 8'hC2, 8'h9A, 8'h62, 8'h92, 8'h94
  };

  // Active-low glyph for a nibble, with the decimal point lit on request.
  function automatic logic [7:0] glyph(input logic [3:0] nib, input logic dp_on);
    logic [7:0] code;
    code = HEX_SEG[nib];
    if (dp_on) code[SEG_DP_BIT] = 1'b0;
    return code;
  endfunction

endpackage

// File: rtl/seg_lz_mask.sv
// Leading-zero suppression mask: bit k is set when digits k..top are all zero.
// Digit 0 is never suppressed so a zero value still shows a single "0".
module seg_lz_mask #(
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   mask
);

  logic upper_zero;

  always_comb begin
    mask       = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero = upper_zero & (value[4*k +: 4] == 4'h0);
      mask[k]    = lz_en & upper_zero;
    end
  end

endmodule

// File: rtl/seg_scan_nx7.sv
// Parametrised N-digit multiplexed 7-segment driver with dp, blanking,
// leading-zero suppression, 16-level PWM and a dead-time phase per slot.
module seg_scan_nx7
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned SCAN_DIV_LOG2   = 18,
  parameter bit          DIG_ACTIVE_HIGH = 1'b1,
  parameter bit          SEG_ACTIVE_LOW  = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp,
  input  logic [NUM_DIGITS-1:0]         blank,
  input  logic                          lz_en,
  input  logic [3:0]                    brightness,
  input  logic                          disp_en,
  output logic [NUM_DIGITS-1:0]         digit_sel,
  output logic [7:0]                    seg,
  output logic                          frame_start,
  output logic [$clog2(NUM_DIGITS)-1:0] cur_digit
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] SEL_IDLE = DIG_ACTIVE_HIGH ? '0 : '1;
  localparam logic [7:0] SEG_IDLE = SEG_ACTIVE_LOW ? SEG_ALL_OFF : ~SEG_ALL_OFF;

  logic [SCAN_DIV_LOG2-1:0] prescaler;
  logic [IW-1:0]            idx;
  logic [3:0]               phase;
  logic                     slot_end;
  logic                     snap;

  logic [4*NUM_DIGITS-1:0]  sh_value;
  logic [NUM_DIGITS-1:0]    sh_dp;
  logic [NUM_DIGITS-1:0]    sh_blank;
  logic                     sh_lz;
  logic [NUM_DIGITS-1:0]    lz_mask;

  logic [3:0]               nib;
  logic                     active;
  logic [NUM_DIGITS-1:0]    sel_next;
  logic [7:0]               seg_next;
  logic [7:0]               code;

  assign phase     = prescaler[SCAN_DIV_LOG2-1 -: 4];
  assign slot_end  = &prescaler;
  assign snap      = slot_end && (idx == LAST_IDX);
  assign cur_digit = idx;

  seg_lz_mask #(
    .NUM_DIGITS(NUM_DIGITS)
  ) u_lz_mask (
    .value(sh_value),
    .lz_en(sh_lz),
    .mask (lz_mask)
  );

  // Scan timing and the once-per-frame shadow capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler   <= '0;
      idx         <= '0;
      sh_value    <= '0;
      sh_dp       <= '0;
      sh_blank    <= '0;
      sh_lz       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      prescaler   <= prescaler + 1'b1;
      frame_start <= snap;
      if (slot_end) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
      if (snap) begin
        sh_value <= value;
        sh_dp    <= dp;
        sh_blank <= blank;
        sh_lz    <= lz_en;
      end
    end
  end

  // brightness and disp_en act directly so dimming responds within a slot.
  always_comb begin
    nib      = sh_value[4*idx +: 4];
    active   = disp_en && (phase != 4'd0) && (phase <= brightness) &&
               !sh_blank[idx] && !lz_mask[idx];
    code     = glyph(nib, sh_dp[idx]);
    sel_next = SEL_IDLE;
    seg_next = SEG_IDLE;
    if (active) begin
      sel_next = DIG_ACTIVE_HIGH ? (NUM_DIGITS'(1) << idx) : ~(NUM_DIGITS'(1) << idx);
      seg_next = SEG_ACTIVE_LOW ? code : ~code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_sel <= SEL_IDLE;
      seg       <= SEG_IDLE;
    end else begin
      digit_sel <= sel_next;
      seg       <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_scan_nx7.sv
// Bench for seg_scan_nx7 (4 digits, 16-cycle slots): cycle-indexed reference
// model feeds an expected queue, a monitor pops and compares every cycle.
module tb_seg_scan_nx7;

  localparam int ND = 4;
  localparam int SL = 4;

  logic          clk;
  logic          rst_n;
  logic [15:0]   value;
  logic [3:0]    dp;
  logic [3:0]    blank;
  logic          lz_en;
  logic [3:0]    brightness;
  logic          disp_en;
  logic [3:0]    digit_sel;
  logic [7:0]    seg;
  logic          frame_start;
  logic [1:0]    cur_digit;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] seg_tab [16] = '{
    8'h0A, 8'h6F, 8'h32, 8'h23, 8'h47, 8'h83, 8'h82, 8'h2F,
    8'h02, 8'h03, 8'h06, 8'hC2, 8'h9A, 8'h62, 8'h92, 8'h94
  };

  seg_scan_nx7 #(
    .NUM_DIGITS(ND), .SCAN_DIV_LOG2(SL), .DIG_ACTIVE_HIGH(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .blank(blank), .lz_en(lz_en),
    .brightness(brightness), .disp_en(disp_en), .digit_sel(digit_sel), .seg(seg),
    .frame_start(frame_start), .cur_digit(cur_digit)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k = clock edges since reset release; slot and digit
  // follow from plain division, shadows are latched on the last cycle of a frame.
  logic [14:0] exp_q[$];
  int unsigned k;
  logic [15:0] m_value;
  logic [3:0]  m_dp, m_blank;
  logic        m_lz;
  int          m_phase, m_digit, m_next_digit;
  logic        m_supp, m_act;
  logic [3:0]  e_sel;
  logic [7:0]  e_seg;
  logic        e_fs;

  always @(negedge clk) begin
    if (!rst_n) begin
      k       = 0;
      m_value = '0;
      m_dp    = '0;
      m_blank = '0;
      m_lz    = 1'b0;
      exp_q.delete();
    end else begin
      m_phase      = k % 16;
      m_digit      = (k / 16) % ND;
      m_next_digit = ((k + 1) / 16) % ND;
      m_supp = m_lz && (m_digit > 0) && ((m_value >> (4 * m_digit)) == 16'h0);
      m_act  = disp_en && (m_phase != 0) && (m_phase <= int'(brightness)) &&
               !m_blank[m_digit] && !m_supp;
      e_sel  = m_act ? 4'(1 << m_digit) : 4'h0;
      e_seg  = m_act ? (seg_tab[(m_value >> (4 * m_digit)) & 16'hF] &
                        (m_dp[m_digit] ? 8'hFD : 8'hFF)) : 8'hFF;
      e_fs   = ((k % (16 * ND)) == (16 * ND - 1));
      exp_q.push_back({e_sel, e_seg, e_fs, 2'(m_next_digit)});
      if (e_fs) begin
        m_value = value;
        m_dp    = dp;
        m_blank = blank;
        m_lz    = lz_en;
      end
      k++;
    end
  end

  // Monitor: outputs settle after each rising edge.
  logic [14:0] got;
  always @(posedge clk) begin
    #1;
    if (rst_n && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("digit_sel", 32'(digit_sel), 32'(got[14:11]));
      check("seg", 32'(seg), 32'(got[10:3]));
      check("frame_start", 32'(frame_start), 32'(got[2]));
      check("cur_digit", 32'(cur_digit), 32'(got[1:0]));
    end
  end

  // Driver tasks: inputs change 3 time units after a rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic wait_frame(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #3;
      if (frame_start) begin
        cycles = i;
        return;
      end
    end
    check("frame_timeout", 32'd1, 32'd0);
  endtask

  task automatic count_active(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #3;
      if (digit_sel != 4'h0) cnt++;
    end
  endtask

  task automatic drive(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                       input logic lz, input logic [3:0] br, input logic en);
    value = v; dp = d; blank = b; lz_en = lz; brightness = br; disp_en = en;
  endtask

  logic [15:0] dir_value [5] = '{16'h1234, 16'h0070, 16'h0102, 16'h0000, 16'hABCD};
  logic [3:0]  dir_dp    [5] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0]  dir_blank [5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic        dir_lz    [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    int c;
    rst_n = 1'b0;
    drive(16'h1234, 4'h0, 4'h0, 1'b0, 4'd15, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("rst_digit_sel", 32'(digit_sel), 32'h0);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_frame_start", 32'(frame_start), 32'h0);
    check("rst_cur_digit", 32'(cur_digit), 32'h0);
    #2;
    rst_n = 1'b1;

    wait_frame(c);
    check("first_frame_cycle", 32'(c), 32'd64);
    wait_frame(c);
    check("frame_period", 32'(c), 32'd64);

    // Directed patterns, each changed mid-frame and held for two frames.
    for (int i = 0; i < 5; i++) begin
      step($urandom_range(1, 60));
      drive(dir_value[i], dir_dp[i], dir_blank[i], dir_lz[i], 4'd15, 1'b1);
      wait_frame(c);
      wait_frame(c);
    end

    // Randomized traffic.
    for (int i = 0; i < 12; i++) begin
      drive(16'($urandom), 4'($urandom), 4'($urandom_range(0, 15) < 4 ? $urandom : 0),
            1'($urandom), 4'($urandom_range(0, 15)), ($urandom_range(0, 7) != 0));
      if ($urandom_range(0, 2) == 0) value[15:8] = 8'h00;
      step($urandom_range(20, 150));
    end

    // PWM duty: brightness 4 lights 4 of 16 cycles in every slot.
    drive(16'h1111, 4'h0, 4'h0, 1'b0, 4'd4, 1'b1);
    wait_frame(c);
    wait_frame(c);
    count_active(64, c);
    check("duty_b4", 32'(c), 32'd16);
    brightness = 4'd0;
    count_active(64, c);
    check("duty_b0", 32'(c), 32'd0);
    brightness = 4'd15;
    disp_en    = 1'b0;
    count_active(64, c);
    check("disp_off", 32'(c), 32'd0);
    disp_en = 1'b1;

    // Asynchronous reset in the digit 2 slot.
    c = 0;
    while (cur_digit != 2'd2 && c < 100) begin
      step(1);
      c++;
    end
    check("reach_digit2", 32'(cur_digit), 32'd2);
    step(4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_digit_sel", 32'(digit_sel), 32'h0);
    check("mid_rst_seg", 32'(seg), 32'hFF);
    check("mid_rst_frame_start", 32'(frame_start), 32'h0);
    check("mid_rst_cur_digit", 32'(cur_digit), 32'h0);
    #2;
    step(2);
    rst_n = 1'b1;
    check("post_rst_cur_digit", 32'(cur_digit), 32'h0);
    wait_frame(c);
    check("post_rst_first_frame", 32'(c), 32'd64);
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
